// File: rtl/fib_pkg.sv
// fib_pkg: shared types and constants for the
// Fibonacci/Lucas sequence engine.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FIB_SEED0 = 0;
  localparam int FIB_SEED1 = 1;
  localparam int LUC_SEED0 = 2;
  localparam int LUC_SEED1 = 1;

  localparam logic MODE_FIB   = 1'b0;
  localparam logic MODE_LUCAS = 1'b1;

endpackage

// File: rtl/fib_hist_buf.sv
// fib_hist_buf: ring buffer of the most recent terms
// with clear, push, indexed read and saturating count.
module fib_hist_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    rd_ptr;

  // Entry storage needs no reset; reads gate on count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[ptr] <= push_data;
  end

  // Write pointer and saturating fill level.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + AW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end
  end

  // Index 0 is the newest entry, counting backwards.
  always_comb begin
    rd_ptr  = ptr - rd_idx - AW'(1);
    rd_data = '0;
    if (CW'(rd_idx) < count) rd_data = mem[rd_ptr];
  end

endmodule

// File: rtl/fib_gen.sv
// fib_gen: n-th Fibonacci/Lucas term, one step per
// cycle, valid/ready result with overflow and history.
module fib_gen
  import fib_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int N_WIDTH    = 16,
  parameter int HIST_DEPTH = 8,
  localparam int HW = $clog2(HIST_DEPTH),
  localparam int CW = $clog2(HIST_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stb,
  input  logic [N_WIDTH-1:0] i_n,
  input  logic               i_mode,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_fib,
  output logic               o_ovf,
  input  logic [HW-1:0]      i_hist_idx,
  output logic [WIDTH-1:0]   o_hist_data,
  output logic [CW-1:0]      o_hist_count
);

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [N_WIDTH-1:0] cnt;
  logic               ovf_a;
  logic               ovf_b;
  logic               accept;
  logic               step;
  logic               last;

  assign {carry, sum} = {1'b0, a} + {1'b0, b};
  assign last = (cnt == '0);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state; abort beats the final step.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (i_stb) state_nx = RUN;
      RUN: begin
        if (i_abort)   state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs and datapath strobes.
  always_comb begin
    o_busy  = 1'b0;
    o_valid = 1'b0;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: accept = i_stb;
      RUN: begin
        o_busy = 1'b1;
        step   = !i_abort;
      end
      DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Term pair, countdown and overflow tracking.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a     <= '0;
      b     <= '0;
      cnt   <= '0;
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
      o_fib <= '0;
      o_ovf <= 1'b0;
    end else if (accept) begin
      if (i_mode == MODE_LUCAS) begin
        a <= WIDTH'(LUC_SEED0);
        b <= WIDTH'(LUC_SEED1);
      end else begin
        a <= WIDTH'(FIB_SEED0);
        b <= WIDTH'(FIB_SEED1);
      end
      cnt   <= i_n;
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else if (step) begin
      if (!last) begin
        a     <= b;
        b     <= sum;
        cnt   <= cnt - N_WIDTH'(1);
        ovf_a <= ovf_b;
        ovf_b <= ovf_a | ovf_b | carry;
      end else begin
        o_fib <= a;
        o_ovf <= ovf_a;
      end
    end
  end

  fib_hist_buf #(
    .WIDTH (WIDTH),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk       (i_clk),
    .reset     (i_reset),
    .clear     (accept),
    .push      (step),
    .push_data (a),
    .rd_idx    (i_hist_idx),
    .rd_data   (o_hist_data),
    .count     (o_hist_count)
  );

endmodule

// File: tb/tb_fib_gen.sv
// tb_fib_gen: directed jobs, results checked by a
// scoreboard monitor on each valid/ready handshake.
module tb_fib_gen;

  localparam int W  = 8;
  localparam int NW = 16;
  localparam int HD = 8;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_stb = 1'b0;
  logic [NW-1:0] i_n = '0;
  logic          i_mode = 1'b0;
  logic          i_abort = 1'b0;
  logic          o_busy;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [W-1:0]  o_fib;
  logic          o_ovf;
  logic [2:0]    i_hist_idx = '0;
  logic [W-1:0]  o_hist_data;
  logic [3:0]    o_hist_count;

  typedef struct packed {
    logic [W-1:0] fib;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   hexp [HD];

  always #10 clk = ~clk;

  fib_gen #(
    .WIDTH      (W),
    .N_WIDTH    (NW),
    .HIST_DEPTH (HD)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_stb        (i_stb),
    .i_n          (i_n),
    .i_mode       (i_mode),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_fib        (o_fib),
    .o_ovf        (o_ovf),
    .i_hist_idx   (i_hist_idx),
    .o_hist_data  (o_hist_data),
    .o_hist_count (o_hist_count)
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic expect_result(int fib, bit ovf);
    exp_t e;
    e.fib = W'(fib);
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Leaves the bench at the negedge after the accept edge.
  task automatic start_job(int n, bit mode);
    @(negedge clk);
    i_stb  = 1'b1;
    i_n    = NW'(n);
    i_mode = mode;
    @(negedge clk);
    i_stb  = 1'b0;
  endtask

  task automatic wait_valid(int n, string name);
    int lat = 0;
    int busy_ok = 1;
    while (!o_valid && lat < n + 20) begin
      if (!o_busy) busy_ok = 0;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, n + 1);
    chk({name, "_busy"}, busy_ok, 1);
  endtask

  task automatic chk_hist(string name, int cnt);
    chk({name, "_hcount"}, int'(o_hist_count), cnt);
    for (int i = 0; i < HD; i++) begin
      i_hist_idx = 3'(i);
      #1;
      chk($sformatf("%s_hist%0d", name, i),
          int'(o_hist_data), hexp[i]);
    end
    i_hist_idx = '0;
  endtask

  // Scoreboard monitor: one pop per handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0d expected none",
                   o_fib);
        end else begin
          e = sb.pop_front();
          chk("result_fib", int'(o_fib), int'(e.fib));
          chk("result_ovf", int'(o_ovf), int'(e.ovf));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_fib", int'(o_fib), 0);
    chk("rst_ovf", int'(o_ovf), 0);
    chk("rst_hcount", int'(o_hist_count), 0);

    expect_result(0, 0);
    start_job(0, 0);
    wait_valid(0, "n0");
    @(negedge clk);
    chk("n0_idle", int'(o_valid), 0);
    hexp = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_hist("n0", 1);

    expect_result(55, 0);
    start_job(10, 0);
    wait_valid(10, "n10");
    @(negedge clk);
    hexp = '{55, 34, 21, 13, 8, 5, 3, 2};
    chk_hist("n10", 8);

    expect_result(11, 0);
    start_job(5, 1);
    wait_valid(5, "luc5");
    @(negedge clk);
    hexp = '{11, 7, 4, 3, 1, 2, 0, 0};
    chk_hist("luc5", 6);

    expect_result(1, 0);
    start_job(1, 0);
    wait_valid(1, "n1");
    @(negedge clk);
    hexp = '{1, 0, 0, 0, 0, 0, 0, 0};
    chk_hist("n1", 2);

    expect_result(233, 0);
    start_job(13, 0);
    wait_valid(13, "n13");
    @(negedge clk);

    expect_result(121, 1);
    start_job(14, 0);
    wait_valid(14, "n14");
    @(negedge clk);
    chk("n14_hold_ovf", int'(o_ovf), 1);

    start_job(20, 0);
    repeat (7) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk("mrst_busy", int'(o_busy), 0);
    chk("mrst_valid", int'(o_valid), 0);
    chk("mrst_fib", int'(o_fib), 0);
    chk("mrst_ovf", int'(o_ovf), 0);
    chk("mrst_hcount", int'(o_hist_count), 0);

    i_ready = 1'b0;
    expect_result(2, 0);
    start_job(3, 0);
    wait_valid(3, "bp");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), int'(o_valid), 1);
      chk($sformatf("bp_fib%0d", k), int'(o_fib), 2);
      i_stb = (k == 2);
      i_n   = NW'(9);
      @(negedge clk);
    end
    i_ready = 1'b1;
    i_stb   = 1'b1;
    @(negedge clk);
    i_stb   = 1'b0;
    chk("bp_idle_busy", int'(o_busy), 0);
    chk("bp_idle_valid", int'(o_valid), 0);
    chk("bp_keep_fib", int'(o_fib), 2);
    repeat (2) @(negedge clk);
    chk("bp_no_queue", int'(o_busy), 0);

    start_job(20, 0);
    repeat (5) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_valid", int'(o_valid), 0);
    hexp = '{3, 2, 1, 1, 0, 0, 0, 0};
    chk_hist("abort", 5);

    start_job(2, 0);
    repeat (2) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_last_busy", int'(o_busy), 0);
    hexp = '{1, 0, 0, 0, 0, 0, 0, 0};
    chk_hist("abort_last", 2);
    repeat (3) @(negedge clk);
    chk("abort_last_valid", int'(o_valid), 0);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
